// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/MDU control path: alu_op classes, alu_ctrl words
// and the sequencer state type.
package alu_pkg;

  localparam logic [1:0] S_T = 2'b00;
  localparam logic [1:0] B_T = 2'b01;
  localparam logic [1:0] R_T = 2'b10;
  localparam logic [1:0] I_T = 2'b11;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLT    = 5'b00101;
  localparam logic [4:0] ALU_SLTU   = 5'b00110;
  localparam logic [4:0] ALU_SLL    = 5'b00111;
  localparam logic [4:0] ALU_SRL    = 5'b01000;
  localparam logic [4:0] ALU_SRA    = 5'b01001;
  localparam logic [4:0] MDU_MUL    = 5'b10000;
  localparam logic [4:0] MDU_MULH   = 5'b10001;
  localparam logic [4:0] MDU_MULHSU = 5'b10010;
  localparam logic [4:0] MDU_MULHU  = 5'b10011;
  localparam logic [4:0] MDU_DIV    = 5'b10100;
  localparam logic [4:0] MDU_DIVU   = 5'b10101;
  localparam logic [4:0] MDU_REM    = 5'b10110;
  localparam logic [4:0] MDU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op/func3/func7 into the 5-bit ALU/MDU control word.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic [1:0] func7,
  output logic [4:0] ctrl,
  output logic       illegal,
  output logic       is_mdu,
  output logic       is_div
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      S_T: ctrl = ALU_ADD;
      B_T: ctrl = ALU_SUB;
      R_T: begin
        case (func7)
          2'b00: begin
            case (func3)
              3'b000:  ctrl = ALU_ADD;
              3'b001:  ctrl = ALU_SLL;
              3'b010:  ctrl = ALU_SLT;
              3'b011:  ctrl = ALU_SLTU;
              3'b100:  ctrl = ALU_XOR;
              3'b101:  ctrl = ALU_SRL;
              3'b110:  ctrl = ALU_OR;
              default: ctrl = ALU_AND;
            endcase
          end
          2'b10: begin
            if (func3 == 3'b000)      ctrl = ALU_SUB;
            else if (func3 == 3'b101) ctrl = ALU_SRA;
            else                      illegal = 1'b1;
          end
          2'b01: begin
            if (EN_M != 0) ctrl = {2'b10, func3};
            else           illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: func7[1] selects arithmetic shift; func7[0] is an immediate bit
        case (func3)
          3'b000: ctrl = ALU_ADD;
          3'b010: ctrl = ALU_SLT;
          3'b011: ctrl = ALU_SLTU;
          3'b100: ctrl = ALU_XOR;
          3'b110: ctrl = ALU_OR;
          3'b111: ctrl = ALU_AND;
          3'b001: begin
            if (func7[1]) illegal = 1'b1;
            else          ctrl = ALU_SLL;
          end
          default: ctrl = func7[1] ? ALU_SRA : ALU_SRL;
        endcase
      end
    endcase
  end

  assign is_mdu = ctrl[4];
  assign is_div = ctrl[4] & ctrl[2];

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU/MDU op sequencer: decodes the request, latches the control word and
// sequences multi-cycle M ops through a start/done handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CTRL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              abort,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        func3,
  input  logic [1:0]        func7,
  input  logic              div_by_zero,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              mdu_start,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [4:0]       dec_ctrl;
  logic             dec_illegal;
  logic             dec_is_mdu;
  logic             dec_is_div;

  alu_op_decode #(.EN_M(EN_M)) u_decode (
    .alu_op  (alu_op),
    .func3   (func3),
    .func7   (func7),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_mdu  (dec_is_mdu),
    .is_div  (dec_is_div)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_ctrl  <= CTRL_W'(ALU_ADD);
      mdu_start <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      count     <= '0;
    end else begin
      mdu_start <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        count   <= '0;
        illegal <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              alu_ctrl <= CTRL_W'(dec_ctrl);
              illegal  <= dec_illegal;
              // Division by zero has an architecturally fixed result; skip the MDU
              if (dec_is_mdu && !(dec_is_div && div_by_zero)) begin
                mdu_start <= 1'b1;
                count     <= dec_is_div ? DIV_CNT : MUL_CNT;
                state     <= BUSY;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          BUSY: begin
            if (count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: three parameterisations share stimulus,
// a reference model predicts per-instance responses, a monitor checks them.
module tb_alu_op_sequencer;

  localparam int ML [3] = '{4, 1, 2};
  localparam int DL [3] = '{32, 3, 5};
  localparam int EM [3] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] alu_op = '0;
  logic [2:0] func3 = '0;
  logic [1:0] func7 = '0;
  logic       div_by_zero = 1'b0;

  logic [4:0] ctrl_o  [3];
  logic       ready_o [3];
  logic       start_o [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       ill_o   [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  alu_op_sequencer #(.EN_M(1), .MUL_LAT(4), .DIV_LAT(32), .CTRL_W(5)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[0]), .abort(abort),
    .alu_op(alu_op), .func3(func3), .func7(func7), .div_by_zero(div_by_zero),
    .alu_ctrl(ctrl_o[0]), .mdu_start(start_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .illegal(ill_o[0]));

  alu_op_sequencer #(.EN_M(1), .MUL_LAT(1), .DIV_LAT(3), .CTRL_W(5)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[1]), .abort(abort),
    .alu_op(alu_op), .func3(func3), .func7(func7), .div_by_zero(div_by_zero),
    .alu_ctrl(ctrl_o[1]), .mdu_start(start_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .illegal(ill_o[1]));

  alu_op_sequencer #(.EN_M(0), .MUL_LAT(2), .DIV_LAT(5), .CTRL_W(5)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[2]), .abort(abort),
    .alu_op(alu_op), .func3(func3), .func7(func7), .div_by_zero(div_by_zero),
    .alu_ctrl(ctrl_o[2]), .mdu_start(start_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .illegal(ill_o[2]));

  typedef struct {
    int ctrl;
    bit ill;
    int done_cyc;
    bit has_start;
    int start_cyc;
    int abort_edge;
  } exp_t;

  exp_t sbq [3][$];
  int free_edge [3] = '{0, 0, 0};
  int busy_lo   [3] = '{0, 0, 0};
  int busy_hi   [3] = '{-1, -1, -1};

  task automatic chk(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, act, exp);
    end
  endtask

  // Reference decode from the instruction tables; kind: 0 ALU, 1 multiply, 2 divide
  function automatic void ref_decode(input int en_m, input int op, input int f3, input int f7,
                                     output int ctrl, output bit ill, output int kind);
    int base [8];
    base = '{0, 7, 5, 6, 4, 8, 3, 2};
    ctrl = 0;
    ill  = 1'b0;
    kind = 0;
    if (op == 0) ctrl = 0;
    else if (op == 1) ctrl = 1;
    else if (op == 2) begin
      if (f7 == 0) ctrl = base[f3];
      else if (f7 == 2 && f3 == 0) ctrl = 1;
      else if (f7 == 2 && f3 == 5) ctrl = 9;
      else if (f7 == 1 && en_m != 0) begin
        ctrl = 16 + f3;
        kind = (f3 < 4) ? 1 : 2;
      end else ill = 1'b1;
    end else begin
      if (f3 == 1 && f7 >= 2) ill = 1'b1;
      else if (f3 == 5 && f7 >= 2) ctrl = 9;
      else ctrl = base[f3];
    end
  endfunction

  task automatic step(input bit v, input bit ab, input int op, input int f3, input int f7,
                      input bit dbz);
    int e;
    int ctrl;
    bit ill;
    int kind;
    int lat;
    exp_t t;
    req_valid   = v;
    abort       = ab;
    alu_op      = op[1:0];
    func3       = f3[2:0];
    func7       = f7[1:0];
    div_by_zero = dbz;
    e = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (ab) begin
        if (sbq[d].size() > 0 && sbq[d][sbq[d].size()-1].done_cyc >= e) begin
          t = sbq[d][sbq[d].size()-1];
          void'(sbq[d].pop_back());
          t.abort_edge = e;
          sbq[d].push_back(t);
        end
        if (free_edge[d] > e) free_edge[d] = e + 1;
        if (busy_hi[d] >= e) busy_hi[d] = e - 1;
      end else if (v && e >= free_edge[d]) begin
        ref_decode(EM[d], op, f3, f7, ctrl, ill, kind);
        if (kind == 2 && dbz) kind = 0;
        lat = (kind == 1) ? ML[d] : (kind == 2) ? DL[d] : 0;
        t.ctrl       = ctrl;
        t.ill        = ill;
        t.done_cyc   = e + lat;
        t.has_start  = (kind != 0);
        t.start_cyc  = e;
        t.abort_edge = 32'h7fffffff;
        sbq[d].push_back(t);
        busy_lo[d]   = e;
        busy_hi[d]   = e + lat;
        free_edge[d] = e + lat + 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_values();
    for (int d = 0; d < 3; d++) begin
      chk("rst_ctrl", d, ctrl_o[d], 0);
      chk("rst_start", d, start_o[d], 0);
      chk("rst_done", d, done_o[d], 0);
      chk("rst_illegal", d, ill_o[d], 0);
      chk("rst_busy", d, busy_o[d], 0);
      chk("rst_ready", d, ready_o[d], 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_values();
    for (int d = 0; d < 3; d++) begin
      sbq[d].delete();
      free_edge[d] = 0;
      busy_lo[d]   = 0;
      busy_hi[d]   = -1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t f;
    bit   has;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        while (sbq[d].size() > 0 && sbq[d][0].abort_edge <= cyc) void'(sbq[d].pop_front());
        has = (sbq[d].size() > 0);
        if (has) f = sbq[d][0];
        chk("busy", d, busy_o[d], (cyc >= busy_lo[d] && cyc <= busy_hi[d]) ? 1 : 0);
        chk("req_ready", d, ready_o[d], (cyc >= busy_lo[d] && cyc <= busy_hi[d]) ? 0 : 1);
        chk("mdu_start", d, start_o[d], (has && f.has_start && f.start_cyc == cyc) ? 1 : 0);
        if (has && f.done_cyc == cyc) begin
          chk("done", d, done_o[d], 1);
          chk("alu_ctrl", d, ctrl_o[d], f.ctrl);
          chk("illegal", d, ill_o[d], f.ill);
          void'(sbq[d].pop_front());
        end else begin
          chk("no_done", d, done_o[d], 0);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    step(1'b1, 1'b0, 2, 0, 2, 1'b0);   // SUB
    idle(3);
    step(1'b1, 1'b0, 2, 0, 1, 1'b0);   // MUL
    idle(8);
    step(1'b1, 1'b0, 2, 5, 1, 1'b1);   // DIVU, divide by zero
    idle(3);
    step(1'b1, 1'b0, 2, 5, 1, 1'b0);   // DIVU, aborted at N+10
    idle(9);
    step(1'b0, 1'b1, 0, 0, 0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 2, 7, 2, 1'b0);   // illegal R-type
    idle(3);
    step(1'b1, 1'b0, 3, 1, 2, 1'b0);   // illegal I-type shift
    idle(3);
    step(1'b1, 1'b0, 3, 5, 3, 1'b0);   // SRAI, func7[0] ignored
    idle(3);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 2, 0, 1, 1'b0);
    idle(6);
    step(1'b1, 1'b0, 2, 4, 1, 1'b0);   // DIV, reset mid-BUSY
    idle(5);
    do_reset();
    idle(2);

    for (int i = 0; i < 400; i++) begin
      step(1'b1 & ($urandom_range(0, 1) == 1), ($urandom_range(0, 24) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0));
    end
    idle(45);
    for (int d = 0; d < 3; d++) chk("drained", d, sbq[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Parametrised successor to the single-cycle ALU control decoder for the multicycle RISC-V core. It decodes ALUOp/func3/func7 into a 5-bit ALU/MDU control word. The word covers the RV32I ALU ops, the shift ops and, optionally, the RV32M ops. Multi-cycle M ops are sequenced through a start/done handshake with an iterative multiply/divide unit. Sits between the main control FSM and the ALU/MDU datapath; the main FSM waits on `done` instead of a fixed cycle count.

Parameters:
- EN_M, 1, 1 = decode RV32M ops (func7[0]=1 in R-type); 0 = flag them illegal
- MUL_LAT, 4, cycles the MDU needs for MUL/MULH/MULHSU/MULHU (>=1)
- DIV_LAT, 32, cycles the MDU needs for DIV/DIVU/REM/REMU (>=1)
- CTRL_W, 5, width of alu_ctrl (fixed at 5 for this encoding)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  main FSM requests an operation
- req_ready  out  1  high when able to accept (state IDLE)
- abort  in  1  synchronous flush; discards the current operation
- alu_op  in  2  00 S-type/load (ADD), 01 branch (SUB), 10 R-type, 11 I-type
- func3  in  3  instr[14:12]
- func7  in  2  {instr[30], instr[25]}
- div_by_zero  in  1  rs2==0, sampled at accept
- alu_ctrl  out  CTRL_W  registered control word
- mdu_start  out  1  one-cycle pulse to the MDU
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  registered; valid while done=1

Behaviour:
- Reset: state IDLE, alu_ctrl=ADD, mdu_start=0, done=0, illegal=0, counter=0, req_ready=1.
- Encoding of alu_ctrl:
  - ALU ops: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLTU 00110, SLL 00111, SRL 01000, SRA 01001.
  - M ops: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - Bit 4 set = MDU op.
- Decode, alu_op=00: ADD.
- Decode, alu_op=01: SUB.
- Decode, alu_op=10 (R-type):
  - func7=00: per func3 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - func7=10: func3 000 -> SUB, 101 -> SRA.
  - func7=01 and EN_M: M op index = func3.
  - Every other combination is illegal.
- Decode, alu_op=11 (I-type):
  - func3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL (func7[1]=0 only).
  - func3 101: SRL if func7[1]=0, SRA if func7[1]=1.
  - func7[0] is ignored.
  - Any other combination is illegal.
- Illegal decode: alu_ctrl=ADD, illegal=1, treated as a single-cycle op. No Z or X output ever.
- FSM states: IDLE, BUSY, DONE.
- IDLE, accept = req_valid & ~abort:
  - Always latch alu_ctrl and illegal.
  - Non-MDU op, illegal op, or DIV/DIVU/REM/REMU with div_by_zero=1: next state DONE, no mdu_start.
  - Otherwise: mdu_start=1 next cycle; counter = (MUL ? MUL_LAT : DIV_LAT)-1; next state BUSY.
- BUSY: counter decrements each cycle. When counter==0, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. req_ready is 0, so back-to-back accept happens at the earliest one cycle after done.
- Latency, accept at edge N:
  - Single-cycle op: done high in cycle N+1.
  - MDU op: mdu_start high in cycle N+1; done high in cycle N+1+LAT.
- req_valid while not IDLE is ignored; no queuing.
- abort has priority over everything, in any state:
  - Next edge: IDLE, counter=0, mdu_start=0, done=0, illegal=0.
  - alu_ctrl holds its last value.
  - No done is produced for the aborted op.
- Reset mid-operation: immediate return to reset values; no done.
- Counter width = $clog2(max(MUL_LAT,DIV_LAT)+1).
- MUL_LAT=1: exactly one BUSY cycle.

Decomposition:
- Shared package alu_pkg: alu_op encodings (S_T/B_T/R_T/I_T), the 18 alu_ctrl constants, and the FSM state encoding (2-bit).
- One natural sub-module, alu_op_decode: purely combinational decode of alu_op/func3/func7/EN_M to {ctrl, illegal, is_mdu, is_div}.
- The sequencer FSM and counter stay in alu_op_sequencer.

Test Plan:
- Reset released, alu_op=10, func3=000, func7=10, req_valid 1 cycle -> alu_ctrl=00001 (SUB), done high the next cycle, illegal=0, mdu_start never high.
- R-type func3=000, func7=01, MUL_LAT=4 -> mdu_start pulses in cycle N+1, done in cycle N+5, busy high cycles N+1..N+5, alu_ctrl=10000.
- DIVU (func3=101, func7=01) with div_by_zero=1 -> alu_ctrl=10101, done at N+1, no mdu_start.
- Same DIVU with div_by_zero=0, DIV_LAT=32 -> done at N+33; abort asserted at N+10 -> IDLE at N+11, no done, req_ready=1.
- Illegal cases: R-type func3=111, func7=10; also EN_M=0 with func7=01 -> alu_ctrl=00000, illegal=1 with done at N+1.
- req_valid held high through a MUL op -> second accept only in the cycle after done; rst asserted mid-BUSY clears all outputs asynchronously.
